// File: rtl/psum_tx_x128.sv
// psum_tx_x128: transmitter side of the accumulator psum link.
// Each column buffers int8 partial sums from the array drain in a small
// show-ahead FIFO and streams them out over its own valid/ready handshake.
// A pass ends when every column has sent (ofmap_size+1)*(ifmap_ch+1) items.
// Optional macro PSUM_TX_ERR_EN enables the sticky overflow / stray-push flags
// on err_o; without it err_o is tied to zero.

// Per-column FIFO, transfer counter and done bit.
module psum_tx_col #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              clr,
    input  logic [CNT_W-1:0]  total,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pready,
    output logic [DATA_W-1:0] dout,
    output logic              pvalid,
    output logic              full,
    output logic              col_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              empty, wr_en, rd_en;

    // Valid comes only from registered state, never from pready.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        wr_en   = run & push & ~full & ~col_done;
        pvalid  = run & ~empty & ~col_done;
        rd_en   = pvalid & pready;
        wr_nxt  = wr_ptr + {{AW{1'b0}}, wr_en};
        rd_nxt  = rd_ptr + {{AW{1'b0}}, rd_en};
        cnt_inc = cnt + CNT_W'(1);
        dout    = pvalid ? mem[rd_ptr[AW-1:0]] : '0;
    end

    // Pointers, registered full flag, transfer count; start flushes leftovers.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full     <= 1'b0;
            cnt      <= '0;
            col_done <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            if (rd_en) begin
                cnt <= cnt_inc;
                if (cnt_inc == total) col_done <= 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible behind pvalid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module psum_tx_x128 #(
    parameter int N_COL      = 128,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SIZE_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [SIZE_W-1:0]       ofmap_size_i,
    input  logic [SIZE_W-1:0]       ifmap_ch_i,
    output logic [SIZE_W-1:0]       ofmap_size_o,
    output logic [SIZE_W-1:0]       ifmap_ch_o,
    input  logic [N_COL-1:0]        push_i,
    input  logic [N_COL*DATA_W-1:0] psum_i,
    output logic [N_COL-1:0]        full_o,
    output logic [N_COL*DATA_W-1:0] psum_o,
    output logic [N_COL-1:0]        pvalid_o,
    input  logic [N_COL-1:0]        pready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              err_o
);
    localparam int CNT_W = 2*SIZE_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [SIZE_W-1:0] ofmap_size;
        logic [SIZE_W-1:0] ifmap_ch;
    } cfg_t;

    state_t                         state_q, state_d;
    cfg_t                           cfg_q;
    logic [CNT_W-1:0]               total_q;
    logic                           run, start_ok;
    logic [N_COL-1:0]               col_done;
    logic [N_COL-1:0][DATA_W-1:0]   din_pk, dout_pk;

    assign din_pk       = psum_i;
    assign psum_o       = dout_pk;
    assign run          = (state_q == S_RUN);
    assign start_ok     = (state_q == S_IDLE) & start_i;
    assign busy_o       = run;
    assign done_o       = (state_q == S_DONE);
    assign ofmap_size_o = cfg_q.ofmap_size;
    assign ifmap_ch_o   = cfg_q.ifmap_ch;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a pass ends once every column has hit its target.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)   state_d = S_RUN;
            S_RUN:   if (&col_done) state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Latch config and precompute the per-column transfer target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            total_q <= '0;
        end else if (start_ok) begin
            cfg_q.ofmap_size <= ofmap_size_i;
            cfg_q.ifmap_ch   <= ifmap_ch_i;
            total_q <= (CNT_W'(ofmap_size_i) + CNT_W'(1)) *
                       (CNT_W'(ifmap_ch_i) + CNT_W'(1));
        end
    end

    for (genvar c = 0; c < N_COL; c++) begin : g_col
        psum_tx_col #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_W      (CNT_W)
        ) u_col (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .clr      (start_ok),
            .total    (total_q),
            .push     (push_i[c]),
            .din      (din_pk[c]),
            .pready   (pready_i[c]),
            .dout     (dout_pk[c]),
            .pvalid   (pvalid_o[c]),
            .full     (full_o[c]),
            .col_done (col_done[c])
        );
    end

`ifdef PSUM_TX_ERR_EN
    logic [N_COL-1:0] ovf_hit, stray_hit;
    logic [1:0]       err_q;

    assign ovf_hit   = push_i & full_o & ~col_done & {N_COL{run}};
    assign stray_hit = push_i & (col_done | {N_COL{~run}});
    assign err_o     = err_q;

    // Sticky error flags; an accepted start wipes them.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) err_q <= 2'b00;
        else                    err_q <= err_q | {|stray_hit, |ovf_hit};
    end
`else
    assign err_o = 2'b00;
`endif
endmodule

// File: tb/tb_psum_tx_x128.sv
// Self-checking bench for psum_tx_x128 against a queue-based reference model.
module tb_psum_tx_x128;
    localparam int N  = 128;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int SW = 8;
`ifdef PSUM_TX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk, rst_n, start_i;
    logic [SW-1:0]   ofmap_size_i, ifmap_ch_i, ofmap_size_o, ifmap_ch_o;
    logic [N-1:0]    push_i, full_o, pvalid_o, pready_i;
    logic [N*DW-1:0] psum_i, psum_o;
    logic            busy_o, done_o;
    logic [1:0]      err_o;

    psum_tx_x128 dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .ofmap_size_i(ofmap_size_i), .ifmap_ch_i(ifmap_ch_i),
        .ofmap_size_o(ofmap_size_o), .ifmap_ch_o(ifmap_ch_o),
        .push_i(push_i), .psum_i(psum_i), .full_o(full_o),
        .psum_o(psum_o), .pvalid_o(pvalid_o), .pready_i(pready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mq [N][$];
    int            mcnt [N];
    bit            mdone [N];
    int            mst;          // 0 idle, 1 run, 2 done
    int            mtotal;
    logic [SW-1:0] mos, mic;
    logic [1:0]    merr;
    int            obs [N];
    int            done_seen;
    int            n_chk, n_pass;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs();
        logic [N-1:0] ev, ef;
        for (int c = 0; c < N; c++) begin
            ev[c] = (mst == 1) && !mdone[c] && (mq[c].size() > 0);
            ef[c] = (mq[c].size() == D);
        end
        chk("pvalid", pvalid_o, ev);
        chk("full", full_o, ef);
        chk("busy", busy_o, mst == 1);
        chk("done", done_o, mst == 2);
        chk("err", err_o, merr);
        chk("ofmap_size_o", ofmap_size_o, mos);
        chk("ifmap_ch_o", ifmap_ch_o, mic);
        for (int c = 0; c < N; c++) begin
            if (ev[c]) chk($sformatf("psum[%0d]", c), psum_o[c*DW +: DW], mq[c][0]);
            if (pvalid_o[c] && pready_i[c]) obs[c]++;
        end
        if (done_o) done_seen++;
    endtask

    task automatic model_step();
        bit all_done, acc;
        if (!rst_n) begin
            mst = 0; mtotal = 0; mos = '0; mic = '0; merr = 2'b00;
            for (int c = 0; c < N; c++) begin
                mq[c].delete(); mcnt[c] = 0; mdone[c] = 1'b0;
            end
            return;
        end
        all_done = 1'b1;
        for (int c = 0; c < N; c++) if (!mdone[c]) all_done = 1'b0;
        for (int c = 0; c < N; c++) begin
            acc = push_i[c] && mst == 1 && !mdone[c] && mq[c].size() < D;
            if (ERR_EN && push_i[c]) begin
                if (mst != 1 || mdone[c]) merr[1] = 1'b1;
                else if (mq[c].size() == D) merr[0] = 1'b1;
            end
            if (mst == 1 && !mdone[c] && mq[c].size() > 0 && pready_i[c]) begin
                void'(mq[c].pop_front());
                mcnt[c]++;
                if (mcnt[c] == mtotal) mdone[c] = 1'b1;
            end
            if (acc) mq[c].push_back(psum_i[c*DW +: DW]);
        end
        case (mst)
            0: if (start_i) begin
                mst = 1; mos = ofmap_size_i; mic = ifmap_ch_i;
                mtotal = (int'(ofmap_size_i) + 1) * (int'(ifmap_ch_i) + 1);
                merr = 2'b00;
                for (int c = 0; c < N; c++) begin
                    mq[c].delete(); mcnt[c] = 0; mdone[c] = 1'b0;
                end
            end
            1: if (all_done) mst = 2;
            default: mst = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_start(input int os, input int ic);
        for (int c = 0; c < N; c++) obs[c] = 0;
        done_seen = 0;
        start_i = 1'b1; ofmap_size_i = SW'(os); ifmap_ch_i = SW'(ic);
        cycle();
        start_i = 1'b0;
    endtask

    task automatic rand_psum();
        for (int w = 0; w < N*DW/32; w++) psum_i[w*32 +: 32] = $urandom();
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (mst != 0 && k < bound) begin cycle(); k++; end
        chk("pass_timeout", k < bound, 1'b1);
    endtask

    task automatic chk_obs(input string tag, input int exp);
        for (int c = 0; c < N; c++) chk($sformatf("%s[%0d]", tag, c), obs[c], exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] first_val;
        int k;
        n_chk = 0; n_pass = 0; done_seen = 0;
        rst_n = 1'b0; start_i = 1'b0; ofmap_size_i = '0; ifmap_ch_i = '0;
        push_i = '0; psum_i = '0; pready_i = '0;
        for (int c = 0; c < N; c++) obs[c] = 0;
        cycle(); cycle();
        chk("rst_psum_zero", psum_o == '0, 1'b1);
        chk("rst_pvalid", pvalid_o, '0);
        chk("rst_err", err_o, 2'b00);
        rst_n = 1'b1;
        cycle();

        // Pass 1: config 15/2, always ready, 48 items per column.
        do_start(15, 2);
        chk("cfg_os", ofmap_size_o, 8'd15);
        chk("cfg_ic", ifmap_ch_o, 8'd2);
        pready_i = '1;
        for (int i = 0; i < 48; i++) begin push_i = '1; rand_psum(); cycle(); end
        push_i = '0;
        wait_idle(50);
        cycle();
        chk_obs("p1_xfers", 48);
        chk("p1_done_pulses", done_seen, 1);
        chk("p1_busy_after", busy_o, 1'b0);

        // Pass 2: column 0 stalled for 20 cycles with 5 pushes.
        do_start(3, 0);
        pready_i = '1; pready_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_i = '1; rand_psum();
            if (i == 0) first_val = psum_i[DW-1:0];
            cycle();
        end
        chk("p2_full0", full_o[0], 1'b1);
        push_i = '0; push_i[0] = 1'b1; rand_psum();
        cycle();
        push_i = '0;
        for (int i = 0; i < 15; i++) cycle();
        chk("p2_hold0", psum_o[DW-1:0], first_val);
        chk("p2_err0", err_o[0], ERR_EN);
        pready_i = '1;
        wait_idle(30);
        chk_obs("p2_xfers", 4);
        chk("p2_done_pulses", done_seen, 1);

        // Pass 3: config 0/0, push 0x7F then 0x80.
        do_start(0, 0);
        push_i = '1;
        for (int c = 0; c < N; c++) psum_i[c*DW +: DW] = 8'h7F;
        cycle();
        for (int c = 0; c < N; c++) psum_i[c*DW +: DW] = 8'h80;
        cycle();
        push_i = '0;
        wait_idle(10);
        chk_obs("p3_xfers", 1);
        chk("p3_done_pulses", done_seen, 1);

        // Push while idle.
        push_i = '1; rand_psum();
        cycle();
        push_i = '0;
        cycle();
        chk("idle_pvalid", pvalid_o, '0);
        chk("idle_err", err_o, ERR_EN ? 2'b10 : 2'b00);

        // Reset mid-pass after about ten transfers.
        do_start(15, 2);
        pready_i = '1;
        for (int i = 0; i < 11; i++) begin push_i = '1; rand_psum(); cycle(); end
        push_i = '0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mrst_psum_zero", psum_o == '0, 1'b1);
        chk("mrst_pvalid", pvalid_o, '0);
        chk("mrst_full", full_o, '0);
        chk("mrst_busy", busy_o, 1'b0);
        chk("mrst_os", ofmap_size_o, '0);
        chk("mrst_err", err_o, 2'b00);
        cycle();

        // Random ready at ~30%, config 3/1.
        do_start(3, 1);
        k = 0;
        while (mst != 0 && k < 3000) begin
            for (int c = 0; c < N; c++) begin
                push_i[c]   = $urandom_range(1);
                pready_i[c] = ($urandom_range(99) < 30);
            end
            rand_psum();
            cycle();
            k++;
        end
        push_i = '0; pready_i = '0;
        chk("p6_timeout", k < 3000, 1'b1);
        cycle();
        chk_obs("p6_xfers", 8);
        chk("p6_done_pulses", done_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/psum_tx_x128.md
Name: psum_tx_x128

Overview:
- Transmitter end of the accumulator psum interface: buffers per-column int8 partial sums from the systolic array drain and streams them to Accumulator_x128 over per-column valid/ready handshakes.
- Counts one full layer pass per column: (ofmap_size+1)*(ifmap_ch+1) transfers.
- Drives the same ofmap_size/ifmap_ch encoding the accumulator consumes, and signals completion when every column has drained.

Parameters:
- N_COL, 128, number of independent columns.
- DATA_W, 8, psum width; two's complement.
- FIFO_DEPTH, 4, per-column buffer depth; power of two, at least 2.
- SIZE_W, 8, width of the ofmap_size and ifmap_ch fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle pulse that latches the config and begins a pass.
- ofmap_size_i  in  SIZE_W  ofmap element count minus 1.
- ifmap_ch_i  in  SIZE_W  channel count minus 1.
- ofmap_size_o  out  SIZE_W  latched config, to the accumulator.
- ifmap_ch_o  out  SIZE_W  latched config, to the accumulator.
- push_i  in  N_COL  per-column write strobe from the array.
- psum_i  in  N_COL*DATA_W  per-column write data; column c occupies bits [c*DATA_W +: DATA_W].
- full_o  out  N_COL  per-column FIFO full (registered).
- psum_o  out  N_COL*DATA_W  psum to the accumulator.
- pvalid_o  out  N_COL  psum valid.
- pready_i  in  N_COL  accumulator ready.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse at the end of a pass.
- err_o  out  2  bit0 = overflow, bit1 = excess or idle push (see Optional Feature).

Behaviour:
- Reset (sync, rst_n=0 at a rising clk edge):
  - FIFOs empty, counters 0, state IDLE.
  - pvalid_o=0, psum_o=0, full_o=0, busy_o=0, done_o=0, err_o=0.
  - ofmap_size_o=0, ifmap_ch_o=0.
  - A reset mid-pass discards all buffered data immediately.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: start_i latches ofmap_size_i and ifmap_ch_i into the _o registers, clears per-column counters and col_done bits, and moves to RUN on the next cycle.
  - RUN: on the cycle all N_COL col_done bits are set, move to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
  - start_i outside IDLE is ignored.
- Target: total = (ofmap_size_o+1)*(ifmap_ch_o+1), computed once at latch time at 2*SIZE_W+1 bits. Max 256*256 = 65536 at default widths.
- Push rules:
  - Accepted only in RUN, when !full_o[c] and !col_done[c].
  - Otherwise the push is dropped and does not affect the FIFO.
  - Push and pop on the same cycle: when not full, both occur and occupancy is unchanged. When full, the pop occurs and the push is dropped (full_o is registered from the previous cycle).
- FIFO: show-ahead. Data pushed in cycle t is visible on psum_o[c] with pvalid_o[c]=1 from cycle t+1 when the FIFO was empty. Order is FIFO order; channel-major, ofmap-index-minor ordering is the producer's responsibility.
- Handshake, per column:
  - Transfer when pvalid_o[c] && pready_i[c] at the rising edge.
  - Once asserted, pvalid_o and psum_o hold stable until the transfer.
  - pvalid_o[c] never depends combinationally on pready_i[c].
  - pvalid_o is 0 outside RUN.
- Counter: each transfer increments cnt[c]. When cnt[c] reaches total, col_done[c]=1 and pvalid_o[c] is forced 0 even if the FIFO still holds data; leftover entries are flushed at the next start_i.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the LSBs are equal.
- busy_o = (state==RUN).

Optional Feature:
- Macro: PSUM_TX_ERR_EN.
- Defined:
  - err_o[0] is a sticky flag set by a push dropped because full_o[c]=1.
  - err_o[1] is a sticky flag set by a push arriving in IDLE/DONE or to a col_done column.
  - Both flags clear on start_i or reset.
- Undefined: err_o is tied to 0 and the flag logic is not generated. Data behaviour is identical in both builds.

Test Plan:
- Config 15/2 with random int8 psums, 16x3 per column on all 128 columns, pready_i always 1 -> 48 transfers per column in push order, done_o pulses once, then busy_o=0.
- Column 0 with pready_i=0 for 20 cycles and 5 pushes -> full_o[0]=1 after 4 pushes, 5th push dropped (err_o[0]=1 with PSUM_TX_ERR_EN). psum_o[0] holds the first value for all 20 cycles; after release it streams the 4 values in order.
- Config 0/0, push 0x7F then 0x80 on every column -> only 0x7F is transferred, col_done is set, pvalid_o drops, done_o asserts. The second push is dropped (err_o[1]=1) or flushed.
- Push while IDLE -> no pvalid_o; err_o[1]=1 with the macro, err_o=2'b00 without it.
- Reset after 10 transfers mid-RUN -> next cycle all outputs are at reset values. A new start_i pass completes correctly with no stale data.
- Random pready_i at 30% duty, config 3/1 -> every column's psum_o sequence matches its pushes in order, with no transfer while pvalid_o=0.
